riscv_wb_stage: RTL

Write-back stage of the RI5CY pipeline. It accepts the instruction leaving EX through the EX/WB handshake, waits for the LSU read response(s), and aligns and sign/zero-extends the load data. It then drives the register-file write port and returns `wb_ready` to EX, which throttles EX while a load is outstanding. It handles misaligned loads that span two words by merging two response beats.

---
 rtl/riscv_defines.sv | 37 +++
 rtl/riscv_load_align.sv | 23 ++
 rtl/riscv_wb_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared encodings for the RI5CY write-back stage: load data types, WB state
// machine states and the load descriptor captured when EX hands over a load.
package riscv_defines;

   typedef enum logic [1:0] {
      DT_WORD = 2'b00,
      DT_HALF = 2'b01,
      DT_BYTE = 2'b10
   } data_type_e;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'b00,
      WB_WAIT1 = 2'b01,
      WB_WAIT2 = 2'b10
   } wb_state_e;

   typedef struct packed {
      logic [1:0] data_type;
      logic       sign_ext;
      logic [1:0] offset;
      logic       misaligned;
   } load_info_t;

   // Encoding 2'b11 is not a legal size and falls back to a full word.
   function automatic logic [31:0] extend_load(input logic [31:0] value,
                                               input logic [1:0]  data_type,
                                               input logic        sign_ext);
      logic [31:0] result;
      case (data_type)
         DT_HALF: result = {{16{sign_ext & value[15]}}, value[15:0]};
         DT_BYTE: result = {{24{sign_ext & value[7]}}, value[7:0]};
         default: result = value;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: shifts a two-word window down by the byte offset
// and sign/zero-extends the selected half or byte. Shared with the LSU model.
module riscv_load_align
   import riscv_defines::*;
(
   input  logic [31:0] rdata_lo,
   input  logic [31:0] rdata_hi,
   input  logic [1:0]  offset,
   input  logic [1:0]  data_type,
   input  logic        sign_ext,
   output logic [31:0] result
);

   logic [63:0] merged;
   logic [31:0] shifted;

   always_comb begin
      merged  = {rdata_hi, rdata_lo};
      shifted = 32'(merged >> {offset, 3'b000});
      result  = extend_load(shifted, data_type, sign_ext);
   end

endmodule

// File: rtl/riscv_wb_stage.sv
// RI5CY write-back stage: waits for LSU read beats, aligns the load data and
// writes it to the register file in the cycle of the final beat.
// Optional macro RISCV_WB_FWD_EN drives the wb_fw_* bypass ports to ID.
module riscv_wb_stage
   import riscv_defines::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   input  logic              regfile_we_i,
   input  logic [ADDR_W-1:0] regfile_waddr_i,
   input  logic [1:0]        data_type_i,
   input  logic              data_sign_ext_i,
   input  logic [1:0]        data_offset_i,
   input  logic              data_misaligned_i,
   input  logic              data_rvalid_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   output logic              wb_ready_o,
   output logic              regfile_we_o,
   output logic [ADDR_W-1:0] regfile_waddr_o,
   output logic [DATA_W-1:0] regfile_wdata_o,
   output logic              wb_fw_we_o,
   output logic [ADDR_W-1:0] wb_fw_waddr_o,
   output logic [DATA_W-1:0] wb_fw_wdata_o
);

   wb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] waddr_q;
   load_info_t        info_q;
   logic [DATA_W-1:0] rdata_lo_q;

   logic              first_beat;
   logic              final_beat;
   logic              load_accept;
   logic [DATA_W-1:0] align_lo;
   logic [DATA_W-1:0] align_hi;
   logic [DATA_W-1:0] aligned_data;

   always_comb begin
      first_beat  = (state_q == WB_WAIT1) && data_rvalid_i && info_q.misaligned;
      final_beat  = ((state_q == WB_WAIT1) && data_rvalid_i && !info_q.misaligned) ||
                    ((state_q == WB_WAIT2) && data_rvalid_i);
      wb_ready_o  = (state_q == WB_IDLE) || final_beat;
      load_accept = ex_valid_i && wb_ready_o && regfile_we_i;

      state_d = state_q;
      case (state_q)
         WB_IDLE: begin
            if (load_accept) state_d = WB_WAIT1;
         end
         WB_WAIT1: begin
            if (first_beat)      state_d = WB_WAIT2;
            else if (final_beat) state_d = load_accept ? WB_WAIT1 : WB_IDLE;
         end
         WB_WAIT2: begin
            if (final_beat) state_d = load_accept ? WB_WAIT1 : WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   // The second beat of a split load supplies the upper word of the window.
   always_comb begin
      align_lo = data_rdata_i;
      align_hi = '0;
      if (state_q == WB_WAIT2) begin
         align_lo = rdata_lo_q;
         align_hi = data_rdata_i;
      end
   end

   riscv_load_align u_load_align (
      .rdata_lo  (align_lo),
      .rdata_hi  (align_hi),
      .offset    (info_q.offset),
      .data_type (info_q.data_type),
      .sign_ext  (info_q.sign_ext),
      .result    (aligned_data)
   );

   // A reset coinciding with the final beat must still suppress the write.
   always_comb begin
      regfile_we_o    = final_beat && !rst;
      regfile_waddr_o = waddr_q;
      regfile_wdata_o = regfile_we_o ? aligned_data : '0;
   end

`ifdef RISCV_WB_FWD_EN
   always_comb begin
      wb_fw_we_o    = regfile_we_o;
      wb_fw_waddr_o = regfile_waddr_o;
      wb_fw_wdata_o = regfile_wdata_o;
   end
`else
   always_comb begin
      wb_fw_we_o    = 1'b0;
      wb_fw_waddr_o = '0;
      wb_fw_wdata_o = '0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WB_IDLE;
         waddr_q    <= '0;
         info_q     <= '0;
         rdata_lo_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_accept) begin
            waddr_q           <= regfile_waddr_i;
            info_q.data_type  <= data_type_i;
            info_q.sign_ext   <= data_sign_ext_i;
            info_q.offset     <= data_offset_i;
            info_q.misaligned <= data_misaligned_i;
         end
         if (first_beat) rdata_lo_q <= data_rdata_i;
      end
   end

endmodule
